alu_iterative: RTL and testbench
================================

// Module: alu_iterative
// PURPOSE
//  Execution-stage ALU fed by the ALU control decoder's 4-bit operation code.
//  Single-step ops (add/sub/logic/compare/LUI pass) finish one edge after acceptance.
//  Shifts run one bit per clock to save area, with a busy/done handshake the core uses to stall PC.
//  Operands come from the register file / immediate mux. result_o goes to the writeback mux.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width
//  SHAMT_WIDTH  5   shift-amount bits taken from b_i[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH)
// PORTS
//  clk              input   1           single clock, rising edge
//  reset            input   1           reset, asynchronous, active-low
//  start_i          input   1           request; sampled only while busy_o==0
//  alu_operation_i  input   4           op code (table below)
//  a_i              input   DATA_WIDTH  operand A (rs1)
//  b_i              input   DATA_WIDTH  operand B (rs2 / immediate)
//  busy_o           output  1           shift in progress; new requests ignored
//  done_o           output  1           one-cycle pulse: result_o updated this cycle
//  result_o         output  DATA_WIDTH  last completed result; holds until next done
//  zero_o           output  1           (result_o == 0), combinational from result_o
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Op codes:
//   0000 ADD   0001 SUB   0010 AND   0011 XOR   1001 OR   1010 LUI (result=b)
//   0111 SLT (signed, result 0/1)   1000 SLTU
//   0100 SLL   0101 SRL   0110 SRA (fill from a[MSB]); all other codes -> result 0
//  ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow/carry output.
//  Reset (async assert): state IDLE, busy_o=0, done_o=0, result_o=0 (so zero_o=1).
//  Reset aborts any in-flight shift and discards it.
//  FSM states: IDLE, SHIFT.
//  IDLE, start_i=1 at edge E0, non-shift op or shift with shamt==0:
//   - result_o <= f(a_i,b_i) (shamt 0: result=a_i); done_o=1 for the next cycle; stay IDLE.
//   - Latency 1 edge; back-to-back starts each cycle allowed, done_o then high each cycle.
//  IDLE, start_i=1, shift with shamt N>=1:
//   - At E0: latch op, acc<=a_i, cnt<=N; go to SHIFT.
//   - busy_o=1 from the cycle after E0 through the cycle after edge E(N-1).
//   - Each SHIFT edge shifts acc by one bit and decrements cnt.
//   - At edge EN (cnt==1): result_o <= final value, done_o=1 next cycle, return to IDLE.
//   - Latency N+1 edges from E0 to done; busy_o=0 in the done cycle, so a new start is accepted then.
//  start_i while busy_o=1: ignored entirely; in-flight op, acc and cnt unaffected.
//  Operands and op are sampled only at E0; later changes to a_i/b_i have no effect.
//  done_o is never high for two cycles per operation; result_o never changes without done_o.
//  start_i=0 in IDLE: nothing changes; done_o=0.
// TESTING
//  1. ADD a=7,b=5 -> done_o 1 edge later, result=12, zero_o=0.
//     SUB a=5,b=5 -> result=0, zero_o=1.
//  2. SLL a=1,b=4 -> busy_o 4 cycles, done after edge E4, result=0x10.
//     ADD start issued mid-shift is ignored, and no extra done_o pulse follows.
//  3. SRA a=0x8000_0000,b=31 -> result=0xFFFF_FFFF after 32 edges.
//     SRL with the same operands -> result=0x0000_0001.
//  4. SLL a=0xDEAD_BEEF,b=0x20 (shamt 0) -> 1-edge latency, busy_o never 1, result=0xDEAD_BEEF.
//  5. Assert reset during SRL a=0xFFFF_0000,b=8 at cnt=3 -> immediately busy_o=0, done_o=0, result=0.
//     After reset release, ADD 1+1 returns 2.
//  6. OR 0xF0|0x0F on 3 consecutive cycles -> done_o high 3 cycles, result=0xFF each.
//     Then code 1111 -> result=0, zero_o=1. SLT a=-1,b=1 -> result=1.

Source files
------------

// File: rtl/alu_iterative.sv
// Execution-stage ALU: single-edge arithmetic/logic ops,
// bit-serial shifts with a busy/done handshake.
module alu_iterative #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE =
    SHAMT_WIDTH'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  acc_nx;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [SHAMT_WIDTH-1:0] cnt_nx;
  logic [3:0]             op;
  logic [3:0]             op_nx;
  logic [DATA_WIDTH-1:0]  result;
  logic [DATA_WIDTH-1:0]  result_nx;
  logic                   done;
  logic                   done_nx;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   lt_s;
  logic                   lt_u;
  logic [DATA_WIDTH-1:0]  calc;
  logic [DATA_WIDTH-1:0]  step;

  assign shamt = b_i[SHAMT_WIDTH-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  assign is_shift = (alu_operation_i == OP_SLL) ||
                    (alu_operation_i == OP_SRL) ||
                    (alu_operation_i == OP_SRA);

  // Shift codes land here only with shamt==0, where the result is a_i.
  always_comb begin
    calc = '0;
    case (alu_operation_i)
      OP_ADD:  calc = a_i + b_i;
      OP_SUB:  calc = a_i - b_i;
      OP_AND:  calc = a_i & b_i;
      OP_XOR:  calc = a_i ^ b_i;
      OP_OR:   calc = a_i | b_i;
      OP_LUI:  calc = b_i;
      OP_SLT:  calc = DATA_WIDTH'(lt_s);
      OP_SLTU: calc = DATA_WIDTH'(lt_u);
      OP_SLL:  calc = a_i;
      OP_SRL:  calc = a_i;
      OP_SRA:  calc = a_i;
      default: calc = '0;
    endcase
  end

  always_comb begin
    step = acc;
    case (op)
      OP_SLL:  step = acc << 1;
      OP_SRL:  step = acc >> 1;
      OP_SRA:  step = {acc[DATA_WIDTH-1],
                       acc[DATA_WIDTH-1:1]};
      default: step = acc;
    endcase
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    op_nx     = op;
    result_nx = result;
    done_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (is_shift && (shamt != '0)) begin
            op_nx    = alu_operation_i;
            acc_nx   = a_i;
            cnt_nx   = shamt;
            state_nx = SHIFT;
          end else begin
            result_nx = calc;
            done_nx   = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_nx = step;
        cnt_nx = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          result_nx = step;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op     <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      op     <= op_nx;
      result <= result_nx;
      done   <= done_nx;
    end
  end

  assign busy_o   = (state == SHIFT);
  assign done_o   = done;
  assign result_o = result;
  assign zero_o   = (result == '0);

endmodule

// File: tb/tb_alu_iterative.sv
// Directed vector table plus hand-written multi-cycle
// sequences for alu_iterative.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_iterative #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .alu_operation_i(op),
    .a_i            (a),
    .b_i            (b),
    .busy_o         (busy),
    .done_o         (done),
    .result_o       (result),
    .zero_o         (zero)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          edges;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic run(input logic [3:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     output int edges,
                     output int busyc);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    busyc = 0;
    while (!done && edges < 100) begin
      if (busy) busyc++;
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int edges;
    int busyc;
    int n;
    int extra;

    tbl.push_back('{4'h0, 32'd7, 32'd5, 32'd12, 1});
    tbl.push_back('{4'h1, 32'd5, 32'd5, 32'd0, 1});
    tbl.push_back('{4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1});
    tbl.push_back('{4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1});
    tbl.push_back('{4'h2, 32'hF0F0_1234, 32'h0FF0_FF00,
                    32'h00F0_1200, 1});
    tbl.push_back('{4'h3, 32'hAAAA_5555, 32'hFFFF_0000,
                    32'h5555_5555, 1});
    tbl.push_back('{4'h9, 32'hF0, 32'h0F, 32'hFF, 1});
    tbl.push_back('{4'hA, 32'd99, 32'h1234_5000,
                    32'h1234_5000, 1});
    tbl.push_back('{4'h7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1});
    tbl.push_back('{4'h7, 32'd1, 32'hFFFF_FFFF, 32'd0, 1});
    tbl.push_back('{4'h8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1});
    tbl.push_back('{4'h8, 32'd1, 32'hFFFF_FFFF, 32'd1, 1});
    tbl.push_back('{4'hF, 32'd3, 32'd4, 32'd0, 1});
    tbl.push_back('{4'hB, 32'd3, 32'd4, 32'd0, 1});
    tbl.push_back('{4'h4, 32'hDEAD_BEEF, 32'h20,
                    32'hDEAD_BEEF, 1});
    tbl.push_back('{4'h4, 32'd1, 32'd4, 32'h10, 5});
    tbl.push_back('{4'h6, 32'h8000_0000, 32'd31,
                    32'hFFFF_FFFF, 32});
    tbl.push_back('{4'h5, 32'h8000_0000, 32'd31,
                    32'h0000_0001, 32});
    tbl.push_back('{4'h5, 32'hF0, 32'd4, 32'h0F, 5});
    tbl.push_back('{4'h6, 32'h7000_0000, 32'd4,
                    32'h0700_0000, 5});
    tbl.push_back('{4'h4, 32'h8000_0001, 32'd1,
                    32'h0000_0002, 2});

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #1 reset = 1'b0;
    #11;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, edges, busyc);
      chk($sformatf("v%0d_result", i), result, tbl[i].res);
      chk($sformatf("v%0d_zero", i), 32'(zero),
          32'(tbl[i].res == 0));
      chk($sformatf("v%0d_edges", i), 32'(edges),
          32'(tbl[i].edges));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busyc),
          32'(tbl[i].edges - 1));
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Start requests during a shift must be ignored.
    start = 1'b1;
    op    = 4'h4;
    a     = 32'd1;
    b     = 32'd4;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    op = 4'h0;
    a  = 32'd3;
    b  = 32'd4;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_result", result, 32'h10);
    chk("mid_latency", 32'(n), 32'd2);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || result !== 32'h10) extra++;
    end
    chk("mid_no_extra_done", 32'(extra), 32'd0);

    // Reset in the middle of a shift, cnt == 3.
    start = 1'b1;
    op    = 4'h5;
    a     = 32'hFFFF_0000;
    b     = 32'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("rst_discarded", 32'(extra), 32'd0);
    run(4'h0, 32'd1, 32'd1, edges, busyc);
    chk("rst_add_result", result, 32'd2);
    chk("rst_add_edges", 32'(edges), 32'd1);

    // Back-to-back single-step starts.
    @(negedge clk);
    start = 1'b1;
    op    = 4'h9;
    a     = 32'hF0;
    b     = 32'h0F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_done", k), 32'(done), 32'd1);
      chk($sformatf("b2b%0d_result", k), result, 32'hFF);
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done_drop", 32'(done), 32'd0);
    chk("b2b_hold", result, 32'hFF);

    run(4'hF, 32'd5, 32'd6, edges, busyc);
    chk("bad_op_result", result, 32'd0);
    chk("bad_op_zero", 32'(zero), 32'd1);
    run(4'h7, 32'hFFFF_FFFF, 32'd1, edges, busyc);
    chk("slt_result", result, 32'd1);
    chk("slt_zero", 32'(zero), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule
